// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
// Hazard detection and operand-forwarding controller for the pipelined MIPS
// core. It sits beside the ID stage and does four jobs:
//   - picks a forwarding source for each ID read port
//     (EX has priority over MEM, which has priority over WB);
//   - raises a load-use stall when a port needs the result of a load in EX;
//   - keeps a busy/countdown scoreboard for multi-cycle (mul/div) results
//     and stalls on RAW or WAW hazards against those registers;
//   - counts stall cycles in a saturating performance counter.
//
// Ports:
//   clk, rst_n            clock (rising edge); asynchronous active-low reset
//   id_valid              ID holds a valid instruction
//   id_src_used/no        per-port source-used flags and packed source numbers
//   id_dst_write/no       ID instruction writes register id_dst_no
//   id_is_long/long_lat   multi-cycle op and its cycles-until-WB
//   ex/mem/wb_regwrite    producer stage writes a register
//   ex/mem/wb_writereg    producer stage destination register
//   ex_is_load            EX holds a load
//   flush                 ID instruction is squashed this cycle
//   fwd_sel               2 bits per port: 00 regfile, 01 EX, 10 MEM, 11 WB
//   stall                 hold PC and IF/ID, inject bubble into EX
//   stall_cause           00 none, 01 load-use, 10 scoreboard RAW, 11 WAW
//   stall_count           saturating count of stall cycles since reset

module hazard_scoreboard_unit #(
   parameter int NUM_SRC    = 2,
   parameter int REG_ADDR_W = 5,
   parameter int LAT_W      = 3,
   parameter int PERF_W     = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          id_valid,
   input  logic [NUM_SRC-1:0]            id_src_used,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_no,
   input  logic                          id_dst_write,
   input  logic [REG_ADDR_W-1:0]         id_dst_no,
   input  logic                          id_is_long,
   input  logic [LAT_W-1:0]              id_long_lat,
   input  logic                          ex_regwrite,
   input  logic                          mem_regwrite,
   input  logic                          wb_regwrite,
   input  logic [REG_ADDR_W-1:0]         ex_writereg,
   input  logic [REG_ADDR_W-1:0]         mem_writereg,
   input  logic [REG_ADDR_W-1:0]         wb_writereg,
   input  logic                          ex_is_load,
   input  logic                          flush,
   output logic [2*NUM_SRC-1:0]          fwd_sel,
   output logic                          stall,
   output logic [1:0]                    stall_cause,
   output logic [PERF_W-1:0]             stall_count
);

   localparam int NUM_REGS = 1 << REG_ADDR_W;

   logic [NUM_REGS-1:0]   busy;
   logic [LAT_W-1:0]      cnt [NUM_REGS];
   logic [REG_ADDR_W-1:0] src_no [NUM_SRC];
   logic [NUM_SRC-1:0]    src_live;
   logic                  load_use;
   logic                  raw_hit;
   logic                  waw_hit;
   logic                  issue;
   logic [LAT_W-1:0]      issue_lat;

   // A port only takes part in hazard checks when the instruction is valid,
   // the port is actually read, and it is not r0 (r0 is hard-wired zero).
   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      assign src_no[k]   = id_src_no[k*REG_ADDR_W +: REG_ADDR_W];
      assign src_live[k] = id_valid & id_src_used[k] & (src_no[k] != '0);
   end

   // Per-port forwarding select and hazard detection. A load in EX cannot
   // forward yet, so that port reads the regfile path and a load-use stall is
   // raised; MEM/WB are deliberately not used as a fallback because they hold
   // an older value of the same register.
   always_comb begin
      fwd_sel  = '0;
      load_use = 1'b0;
      raw_hit  = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (src_live[k]) begin
            if (ex_regwrite && (ex_writereg == src_no[k])) begin
               if (ex_is_load) begin
                  load_use = 1'b1;
               end else begin
                  fwd_sel[2*k +: 2] = 2'b01;
               end
            end else if (mem_regwrite && (mem_writereg == src_no[k])) begin
               fwd_sel[2*k +: 2] = 2'b10;
            end else if (wb_regwrite && (wb_writereg == src_no[k])) begin
               fwd_sel[2*k +: 2] = 2'b11;
            end
            if (busy[src_no[k]]) begin
               raw_hit = 1'b1;
            end
         end
      end
   end

   // busy[0] is never set, so a write to r0 can never produce a WAW stall.
   assign waw_hit = id_valid & id_dst_write & busy[id_dst_no];

   assign stall = id_valid & ~flush & (load_use | raw_hit | waw_hit);

   // Cause encoding follows priority load-use > RAW > WAW and reads 00
   // whenever no stall is raised (including flushed cycles).
   always_comb begin
      stall_cause = 2'b00;
      if (stall) begin
         if (load_use) begin
            stall_cause = 2'b01;
         end else if (raw_hit) begin
            stall_cause = 2'b10;
         end else begin
            stall_cause = 2'b11;
         end
      end
   end

   // A long op is accepted only when it actually leaves ID this cycle. A
   // latency of zero is treated as one so the entry is busy for at least one
   // cycle and the value is then picked up through the WB forward path.
   assign issue     = id_valid & ~stall & ~flush & id_is_long & id_dst_write
                      & (id_dst_no != '0);
   assign issue_lat = (id_long_lat == '0) ? LAT_W'(1) : id_long_lat;

   // Scoreboard: each busy entry counts down once per cycle and clears on the
   // edge after it reaches one. Flush does not touch entries already issued
   // because those long ops always run to completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (issue && (id_dst_no == REG_ADDR_W'(r))) begin
               busy[r] <= 1'b1;
               cnt[r]  <= issue_lat;
            end else if (busy[r]) begin
               if (cnt[r] <= LAT_W'(1)) begin
                  busy[r] <= 1'b0;
                  cnt[r]  <= '0;
               end else begin
                  cnt[r]  <= cnt[r] - LAT_W'(1);
               end
            end
         end
      end
   end

   // Stall-cycle counter, holding at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (stall && (stall_count != '1)) begin
         stall_count <= stall_count + PERF_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit
// Directed bench for hazard_scoreboard_unit (NUM_SRC=2, REG_ADDR_W=5,
// LAT_W=3, PERF_W=4). Inputs change 1 time unit after a rising edge and
// outputs are compared 2 units later, well away from the next edge.

module tb_hazard_scoreboard_unit;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [1:0]  id_src_used;
   logic [9:0]  id_src_no;
   logic        id_dst_write;
   logic [4:0]  id_dst_no;
   logic        id_is_long;
   logic [2:0]  id_long_lat;
   logic        ex_regwrite;
   logic        mem_regwrite;
   logic        wb_regwrite;
   logic [4:0]  ex_writereg;
   logic [4:0]  mem_writereg;
   logic [4:0]  wb_writereg;
   logic        ex_is_load;
   logic        flush;
   logic [3:0]  fwd_sel;
   logic        stall;
   logic [1:0]  stall_cause;
   logic [3:0]  stall_count;

   int checks = 0;
   int errors = 0;

   hazard_scoreboard_unit #(
      .NUM_SRC(2), .REG_ADDR_W(5), .LAT_W(3), .PERF_W(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_src_used(id_src_used), .id_src_no(id_src_no),
      .id_dst_write(id_dst_write), .id_dst_no(id_dst_no),
      .id_is_long(id_is_long), .id_long_lat(id_long_lat),
      .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite),
      .wb_regwrite(wb_regwrite), .ex_writereg(ex_writereg),
      .mem_writereg(mem_writereg), .wb_writereg(wb_writereg),
      .ex_is_load(ex_is_load), .flush(flush),
      .fwd_sel(fwd_sel), .stall(stall), .stall_cause(stall_cause),
      .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the ID-stage instruction fields.
   task automatic applyStimulus(input logic valid, input logic [1:0] used,
                                input logic [4:0] src1, input logic [4:0] src0,
                                input logic dwr, input logic [4:0] dst,
                                input logic is_long, input logic [2:0] lat,
                                input logic fl);
      id_valid     = valid;
      id_src_used  = used;
      id_src_no    = {src1, src0};
      id_dst_write = dwr;
      id_dst_no    = dst;
      id_is_long   = is_long;
      id_long_lat  = lat;
      flush        = fl;
   endtask

   // Drive the producer stages behind ID.
   task automatic applyStages(input logic exw, input logic [4:0] exr,
                              input logic exl, input logic memw,
                              input logic [4:0] memr, input logic wbw,
                              input logic [4:0] wbr);
      ex_regwrite  = exw;
      ex_writereg  = exr;
      ex_is_load   = exl;
      mem_regwrite = memw;
      mem_writereg = memr;
      wb_regwrite  = wbw;
      wb_writereg  = wbr;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 2'b00, 5'd0, 5'd0, 0, 5'd0, 0, 3'd0, 0);
      applyStages(0, 5'd0, 0, 0, 5'd0, 0, 5'd0);
      #2;
      checkOutput("rst_stall", {31'd0, stall}, 32'd0);
      checkOutput("rst_cause", {30'd0, stall_cause}, 32'd0);
      checkOutput("rst_fwd", {28'd0, fwd_sel}, 32'd0);
      checkOutput("rst_count", {28'd0, stall_count}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Reset mid-operation: r5 busy with a long countdown and a WAW stall.
      $display("[TB] reset with scoreboard entry pending");
      applyStimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd5, 1, 3'd7, 0);
      #2;
      checkOutput("issue_r5_nostall", {31'd0, stall}, 32'd0);
      tick();
      applyStimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd5, 0, 3'd0, 0);
      #2;
      checkOutput("waw_r5_stall", {31'd0, stall}, 32'd1);
      checkOutput("waw_r5_cause", {30'd0, stall_cause}, 32'd3);
      tick();
      checkOutput("waw_r5_count", {28'd0, stall_count}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_count", {28'd0, stall_count}, 32'd0);
      checkOutput("midrst_stall", {31'd0, stall}, 32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      checkOutput("postrst_stall", {31'd0, stall}, 32'd0);
      checkOutput("postrst_fwd", {28'd0, fwd_sel}, 32'd0);
      checkOutput("postrst_count", {28'd0, stall_count}, 32'd0);

      // Forward priority EX > MEM > WB on port 0, then r0 never forwards.
      $display("[TB] forwarding priority");
      applyStimulus(1, 2'b01, 5'd0, 5'd3, 0, 5'd0, 0, 3'd0, 0);
      applyStages(1, 5'd3, 0, 1, 5'd3, 1, 5'd3);
      #2;
      checkOutput("fwd_ex", {28'd0, fwd_sel}, 32'h1);
      applyStages(0, 5'd3, 0, 1, 5'd3, 1, 5'd3);
      #1;
      checkOutput("fwd_mem", {28'd0, fwd_sel}, 32'h2);
      applyStages(0, 5'd3, 0, 0, 5'd3, 1, 5'd3);
      #1;
      checkOutput("fwd_wb", {28'd0, fwd_sel}, 32'h3);
      applyStimulus(1, 2'b01, 5'd0, 5'd0, 0, 5'd0, 0, 3'd0, 0);
      applyStages(1, 5'd0, 0, 1, 5'd0, 1, 5'd0);
      #1;
      checkOutput("fwd_r0", {28'd0, fwd_sel}, 32'h0);
      applyStimulus(1, 2'b11, 5'd3, 5'd4, 0, 5'd0, 0, 3'd0, 0);
      applyStages(1, 5'd4, 0, 1, 5'd3, 0, 5'd0);
      #1;
      checkOutput("fwd_both_ports", {28'd0, fwd_sel}, 32'h9);
      checkOutput("fwd_no_stall", {31'd0, stall}, 32'd0);

      // Load-use on port 1: no MEM fallback, one stall cycle, then MEM forward.
      $display("[TB] load-use");
      applyStimulus(1, 2'b10, 5'd7, 5'd0, 0, 5'd0, 0, 3'd0, 0);
      applyStages(1, 5'd7, 1, 1, 5'd7, 0, 5'd0);
      #1;
      checkOutput("lu_stall", {31'd0, stall}, 32'd1);
      checkOutput("lu_cause", {30'd0, stall_cause}, 32'd1);
      checkOutput("lu_fwd", {28'd0, fwd_sel}, 32'h0);
      tick();
      applyStages(0, 5'd0, 0, 1, 5'd7, 0, 5'd0);
      #2;
      checkOutput("lu_after_stall", {31'd0, stall}, 32'd0);
      checkOutput("lu_after_fwd", {28'd0, fwd_sel}, 32'h8);
      checkOutput("lu_count", {28'd0, stall_count}, 32'd1);

      // Scoreboard RAW: long op to r9 with latency 3 stalls a reader 3 cycles.
      $display("[TB] scoreboard RAW");
      applyStages(0, 5'd0, 0, 0, 5'd0, 0, 5'd0);
      applyStimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd9, 1, 3'd3, 0);
      tick();
      applyStimulus(1, 2'b01, 5'd0, 5'd9, 1, 5'd10, 0, 3'd0, 0);
      #2;
      checkOutput("raw_c1_stall", {31'd0, stall}, 32'd1);
      checkOutput("raw_c1_cause", {30'd0, stall_cause}, 32'd2);
      tick();
      checkOutput("raw_c2_stall", {31'd0, stall}, 32'd1);
      tick();
      checkOutput("raw_c3_stall", {31'd0, stall}, 32'd1);
      checkOutput("raw_c3_cause", {30'd0, stall_cause}, 32'd2);
      tick();
      applyStages(0, 5'd0, 0, 0, 5'd0, 1, 5'd9);
      #1;
      checkOutput("raw_release", {31'd0, stall}, 32'd0);
      checkOutput("raw_wb_fwd", {28'd0, fwd_sel}, 32'h3);
      checkOutput("raw_count", {28'd0, stall_count}, 32'd4);

      // WAW with latency 0: r4 busy exactly one cycle.
      $display("[TB] WAW with zero latency");
      applyStages(0, 5'd0, 0, 0, 5'd0, 0, 5'd0);
      applyStimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd4, 1, 3'd0, 0);
      tick();
      applyStimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd4, 0, 3'd0, 0);
      #2;
      checkOutput("waw_stall", {31'd0, stall}, 32'd1);
      checkOutput("waw_cause", {30'd0, stall_cause}, 32'd3);
      tick();
      checkOutput("waw_release", {31'd0, stall}, 32'd0);

      // A long op to r0 is never tracked.
      applyStimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd0, 1, 3'd3, 0);
      tick();
      applyStimulus(1, 2'b11, 5'd0, 5'd0, 1, 5'd0, 0, 3'd0, 0);
      #2;
      checkOutput("r0_never_busy", {31'd0, stall}, 32'd0);

      // Flush suppresses stall and issue but not in-flight entries.
      $display("[TB] flush");
      applyStages(1, 5'd7, 1, 0, 5'd0, 0, 5'd0);
      applyStimulus(1, 2'b10, 5'd7, 5'd0, 1, 5'd12, 1, 3'd2, 1);
      #1;
      checkOutput("flush_stall", {31'd0, stall}, 32'd0);
      checkOutput("flush_cause", {30'd0, stall_cause}, 32'd0);
      tick();
      applyStages(0, 5'd0, 0, 0, 5'd0, 0, 5'd0);
      applyStimulus(1, 2'b01, 5'd0, 5'd12, 0, 5'd0, 0, 3'd0, 0);
      #2;
      checkOutput("flush_no_issue", {31'd0, stall}, 32'd0);
      applyStimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd13, 1, 3'd2, 0);
      tick();
      applyStimulus(1, 2'b01, 5'd0, 5'd13, 0, 5'd0, 0, 3'd0, 1);
      #2;
      checkOutput("flush_reader_nostall", {31'd0, stall}, 32'd0);
      tick();
      applyStimulus(1, 2'b01, 5'd0, 5'd13, 0, 5'd0, 0, 3'd0, 0);
      #2;
      checkOutput("inflight_kept_stall", {31'd0, stall}, 32'd1);
      checkOutput("inflight_kept_cause", {30'd0, stall_cause}, 32'd2);
      tick();
      checkOutput("inflight_done", {31'd0, stall}, 32'd0);
      checkOutput("flush_count", {28'd0, stall_count}, 32'd6);

      // Saturation of the 4-bit stall counter after 20 stall cycles.
      $display("[TB] counter saturation");
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      applyStages(1, 5'd7, 1, 0, 5'd0, 0, 5'd0);
      applyStimulus(1, 2'b10, 5'd7, 5'd0, 0, 5'd0, 0, 3'd0, 0);
      for (int i = 0; i < 10; i++) tick();
      checkOutput("sat_count_10", {28'd0, stall_count}, 32'd10);
      for (int i = 0; i < 10; i++) tick();
      checkOutput("sat_count_20", {28'd0, stall_count}, 32'd15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
